// File: rtl/blake_pkg.sv
// Shared widths, core latency and scheduler state encoding for the BLAKE-512 nonce search.
package blake_pkg;

  localparam int unsigned HDR_W    = 640;
  localparam int unsigned HASH_W   = 512;
  localparam int unsigned NONCE_W  = 32;
  localparam int unsigned CORE_LAT = 129;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_FINISH
  } sched_state_e;

endpackage

// File: rtl/blake_nonce_scheduler.sv
// Walks an inclusive nonce range through one blake_hw core, one hash in flight,
// stopping on the first hash <= target, on range end, on abort, or on a core timeout.
module blake_nonce_scheduler
  import blake_pkg::*;
#(
  parameter int unsigned RDY_TIMEOUT = 200
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               start,
  input  logic               abort,
  input  logic [HDR_W-1:0]   header,
  input  logic [NONCE_W-1:0] nonce_start,
  input  logic [NONCE_W-1:0] nonce_end,
  input  logic [HASH_W-1:0]  target,
  output logic               core_ena,
  output logic [HDR_W-1:0]   core_din,
  input  logic               core_rdy,
  input  logic [HASH_W-1:0]  core_dout,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [NONCE_W-1:0] found_nonce,
  output logic [HASH_W-1:0]  found_hash,
  output logic [NONCE_W-1:0] hash_count,
  output logic               err_timeout
);

  localparam int unsigned     TO_W    = $clog2(RDY_TIMEOUT + 1);
  localparam int unsigned     TMPL_W  = HDR_W - NONCE_W;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(RDY_TIMEOUT - 1);

  sched_state_e        state_q;
  sched_state_e        state_d;

  logic [TMPL_W-1:0]   hdr_q;
  logic [NONCE_W-1:0]  nonce_q;
  logic [NONCE_W-1:0]  nonce_end_q;
  logic [HASH_W-1:0]   target_q;
  logic [HASH_W-1:0]   hash_q;
  logic [TO_W-1:0]     to_cnt_q;
  logic                abort_q;
  logic                hit_q;

  logic                range_empty;
  logic                rdy_expired;
  logic                last_nonce;
  logic                stop_search;

  // The low header word is always overwritten by the nonce.
  logic                unused_hdr_lo;
  assign unused_hdr_lo = ^header[NONCE_W-1:0];

  assign core_din = {hdr_q, nonce_q};

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    range_empty = (nonce_end < nonce_start);
    rdy_expired = (to_cnt_q == TO_LAST);
    last_nonce  = (nonce_q == nonce_end_q);
    stop_search = hit_q || last_nonce || abort_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = range_empty ? S_FINISH : S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core_rdy) begin
          state_d = S_NEXT;
        end else if (rdy_expired) begin
          state_d = S_FINISH;
        end
      end
      S_NEXT: begin
        state_d = stop_search ? S_FINISH : S_ISSUE;
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs; core_ena/busy follow the next state so they align with it.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      core_ena    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      found_nonce <= '0;
      found_hash  <= '0;
      hash_count  <= '0;
      err_timeout <= 1'b0;
      hdr_q       <= '0;
      nonce_q     <= '0;
      nonce_end_q <= '0;
      target_q    <= '0;
      hash_q      <= '0;
      to_cnt_q    <= '0;
      abort_q     <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      core_ena <= (state_d == S_ISSUE);
      busy     <= (state_d != S_IDLE);
      done     <= (state_q == S_FINISH);

      if (state_q != S_IDLE) begin
        abort_q <= abort_q | abort;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            hdr_q       <= header[HDR_W-1:NONCE_W];
            nonce_q     <= nonce_start;
            nonce_end_q <= nonce_end;
            target_q    <= target;
            found       <= 1'b0;
            found_nonce <= '0;
            found_hash  <= '0;
            hash_count  <= '0;
            err_timeout <= 1'b0;
            abort_q     <= 1'b0;
            hit_q       <= 1'b0;
          end
        end
        S_ISSUE: begin
          to_cnt_q <= '0;
        end
        S_WAIT: begin
          if (core_rdy) begin
            hit_q      <= (core_dout <= target_q);
            hash_q     <= core_dout;
            hash_count <= hash_count + NONCE_W'(1);
          end else if (rdy_expired) begin
            err_timeout <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        S_NEXT: begin
          // Equality is tested before incrementing, so the top nonce never wraps.
          if (hit_q) begin
            found       <= 1'b1;
            found_nonce <= nonce_q;
            found_hash  <= hash_q;
          end else if (!last_nonce && !abort_q) begin
            nonce_q <= nonce_q + NONCE_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blake_nonce_scheduler.sv
// Directed bench for blake_nonce_scheduler with a fixed-latency core stub and a done/ena scoreboard.
module tb_blake_nonce_scheduler;
  import blake_pkg::*;

  localparam int unsigned RDY_TIMEOUT = 200;
  localparam int unsigned PERIOD      = CORE_LAT + 2;

  typedef struct {
    logic              found;
    logic [31:0]       nonce;
    logic [511:0]      hash;
    logic [31:0]       count;
    logic              err;
    int unsigned       done_cyc;
  } exp_t;

  logic               clk;
  logic               rstb;
  logic               start;
  logic               abort;
  logic [HDR_W-1:0]   header;
  logic [NONCE_W-1:0] nonce_start;
  logic [NONCE_W-1:0] nonce_end;
  logic [HASH_W-1:0]  target;
  logic               core_ena;
  logic [HDR_W-1:0]   core_din;
  logic               core_rdy;
  logic [HASH_W-1:0]  core_dout;
  logic               busy;
  logic               done;
  logic               found;
  logic [NONCE_W-1:0] found_nonce;
  logic [HASH_W-1:0]  found_hash;
  logic [NONCE_W-1:0] hash_count;
  logic               err_timeout;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc = 0;
  int unsigned search_id = 0;

  exp_t              sb[$];
  logic [31:0]       ena_q[$];
  logic [HDR_W-1:0]  hdr_lat;
  logic              stub_dead;

  localparam logic [511:0] ONES = {512{1'b1}};
  localparam logic [511:0] ZERO = '0;

  blake_nonce_scheduler #(.RDY_TIMEOUT(RDY_TIMEOUT)) dut (
    .clk         (clk),
    .rstb        (rstb),
    .start       (start),
    .abort       (abort),
    .header      (header),
    .nonce_start (nonce_start),
    .nonce_end   (nonce_end),
    .target      (target),
    .core_ena    (core_ena),
    .core_din    (core_din),
    .core_rdy    (core_rdy),
    .core_dout   (core_dout),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .found_nonce (found_nonce),
    .found_hash  (found_hash),
    .hash_count  (hash_count),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [511:0] model_hash(input logic [31:0] n);
    return {16{~n}} | 512'd1;
  endfunction

  task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Core stub: core_rdy sampled CORE_LAT edges after core_ena; dout is garbage outside rdy.
  int unsigned lat_cnt;
  logic [31:0] stub_nonce;
  always @(posedge clk) begin
    if (!rstb) begin
      lat_cnt    <= 0;
      core_rdy   <= 1'b0;
      stub_nonce <= '0;
    end else begin
      core_rdy <= 1'b0;
      if (core_ena) begin
        lat_cnt    <= 1;
        stub_nonce <= core_din[31:0];
      end else if (lat_cnt == CORE_LAT - 1) begin
        lat_cnt  <= 0;
        core_rdy <= !stub_dead;
      end else if (lat_cnt != 0) begin
        lat_cnt <= lat_cnt + 1;
      end
    end
  end
  assign core_dout = core_rdy ? model_hash(stub_nonce) : ~model_hash(stub_nonce);

  // core_ena monitor: expected nonce, latched header, spacing inside a search.
  int unsigned last_ena;
  int unsigned last_sid = 0;
  always @(negedge clk) begin
    if (rstb && core_ena === 1'b1) begin
      check("ena_with_rdy", 640'(core_rdy), 640'(0));
      if (ena_q.size() == 0) begin
        check("ena_unexpected", 640'(core_ena), 640'(0));
      end else begin
        check("din_nonce", 640'(core_din[31:0]), 640'(ena_q.pop_front()));
        check("din_header", 640'(core_din[639:32]), 640'(hdr_lat[639:32]));
      end
      if (last_sid == search_id) check("ena_spacing", 640'(cyc - last_ena), 640'(PERIOD));
      last_ena = cyc;
      last_sid = search_id;
    end
  end

  // done monitor: pops the scoreboard at the expected cycle and checks the results.
  always @(negedge clk) begin
    logic exp_done;
    exp_t e;
    exp_done = (sb.size() != 0) && (cyc == sb[0].done_cyc);
    if (rstb && (done === 1'b1 || exp_done)) begin
      check("done_timing", 640'(done), 640'(exp_done));
      if (exp_done) begin
        e = sb.pop_front();
        check("found", 640'(found), 640'(e.found));
        check("found_nonce", 640'(found_nonce), 640'(e.nonce));
        check("found_hash", 640'(found_hash), 640'(e.hash));
        check("hash_count", 640'(hash_count), 640'(e.count));
        check("err_timeout", 640'(err_timeout), 640'(e.err));
        check("busy_at_done", 640'(busy), 640'(0));
        check("ena_left", 640'(ena_q.size()), 640'(0));
      end
    end
  end

  task automatic new_header();
    for (int i = 0; i < 20; i++) header[i*32 +: 32] = $urandom();
  endtask

  task automatic launch(input logic [31:0] ns, input logic [31:0] ne, input logic [511:0] tg,
                        input logic push, input logic e_found, input logic [31:0] e_nonce,
                        input logic [511:0] e_hash, input logic [31:0] e_count, input logic e_err,
                        input int unsigned done_off, output int unsigned k);
    exp_t e;
    @(negedge clk);
    nonce_start = ns;
    nonce_end   = ne;
    target      = tg;
    start       = 1'b1;
    hdr_lat     = header;
    search_id++;
    k = cyc + 1;
    if (push) begin
      e.found = e_found; e.nonce = e_nonce; e.hash = e_hash;
      e.count = e_count; e.err = e_err; e.done_cyc = k + done_off;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    new_header();
  endtask

  task automatic wait_done(input int unsigned budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("done_wait_expired", 640'(sb.size()), 640'(0));
      sb.delete();
    end
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 640'(busy), 640'(0));
    check({tag, "_done"}, 640'(done), 640'(0));
    check({tag, "_found"}, 640'(found), 640'(0));
    check({tag, "_found_nonce"}, 640'(found_nonce), 640'(0));
    check({tag, "_found_hash"}, 640'(found_hash), 640'(0));
    check({tag, "_hash_count"}, 640'(hash_count), 640'(0));
    check({tag, "_err_timeout"}, 640'(err_timeout), 640'(0));
    check({tag, "_core_ena"}, 640'(core_ena), 640'(0));
    check({tag, "_core_din"}, core_din, 640'(0));
  endtask

  initial begin
    int unsigned k;
    rstb = 1'b0; start = 1'b0; abort = 1'b0; stub_dead = 1'b0;
    nonce_start = '0; nonce_end = '0; target = '0;
    new_header();
    hdr_lat = header;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rstb = 1'b1;
    @(negedge clk);

    // Single nonce, always-hit target; results must hold after done.
    ena_q.push_back(32'd5);
    launch(32'd5, 32'd5, ONES, 1'b1, 1'b1, 32'd5, model_hash(32'd5), 32'd1, 1'b0, 1 + PERIOD, k);
    wait_done(400);
    repeat (10) @(negedge clk);
    check("hold_found", 640'(found), 640'(1));
    check("hold_found_nonce", 640'(found_nonce), 640'(5));
    check("hold_found_hash", 640'(found_hash), 640'(model_hash(32'd5)));

    // Abort while idle is dropped; start while busy is ignored.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    for (int n = 0; n < 4; n++) ena_q.push_back(32'(n));
    launch(32'd0, 32'd3, ZERO, 1'b1, 1'b0, 32'd0, ZERO, 32'd4, 1'b0, 1 + 4 * PERIOD, k);
    wait_until(k + 20);
    nonce_start = 32'd100; nonce_end = 32'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1000);

    // Top of the nonce space: one hash, no wrap.
    ena_q.push_back(32'hFFFF_FFFF);
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, ZERO, 1'b1, 1'b0, 32'd0, ZERO, 32'd1, 1'b0, 1 + PERIOD, k);
    wait_done(400);
    repeat (20) @(negedge clk);
    check("nowrap_busy", 640'(busy), 640'(0));
    check("nowrap_count", 640'(hash_count), 640'(1));

    // Empty range.
    launch(32'd10, 32'd2, ONES, 1'b1, 1'b0, 32'd0, ZERO, 32'd0, 1'b0, 1, k);
    wait_done(50);

    // Abort mid-WAIT: in-flight hash completes, miss then hit.
    ena_q.push_back(32'd0);
    launch(32'd0, 32'd9, ZERO, 1'b1, 1'b0, 32'd0, ZERO, 32'd1, 1'b0, 1 + PERIOD, k);
    wait_until(k + 51);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(400);
    ena_q.push_back(32'd0);
    launch(32'd0, 32'd9, ONES, 1'b1, 1'b1, 32'd0, model_hash(32'd0), 32'd1, 1'b0, 1 + PERIOD, k);
    wait_until(k + 51);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(400);

    // hash == target is a hit; target one below moves the hit to the next nonce.
    for (int n = 5; n <= 7; n++) ena_q.push_back(32'(n));
    launch(32'd5, 32'd9, model_hash(32'd7), 1'b1, 1'b1, 32'd7, model_hash(32'd7), 32'd3, 1'b0,
           1 + 3 * PERIOD, k);
    wait_done(1000);
    for (int n = 5; n <= 8; n++) ena_q.push_back(32'(n));
    launch(32'd5, 32'd9, model_hash(32'd7) - 512'd1, 1'b1, 1'b1, 32'd8, model_hash(32'd8), 32'd4,
           1'b0, 1 + 4 * PERIOD, k);
    wait_done(1000);

    // Dead core: timeout fires RDY_TIMEOUT+2 cycles after core_ena.
    stub_dead = 1'b1;
    ena_q.push_back(32'd0);
    launch(32'd0, 32'd0, ONES, 1'b1, 1'b0, 32'd0, ZERO, 32'd0, 1'b1, RDY_TIMEOUT + 2, k);
    wait_done(600);
    stub_dead = 1'b0;

    // Reset in the second WAIT abandons the search without a done pulse.
    ena_q.push_back(32'd0);
    ena_q.push_back(32'd1);
    launch(32'd0, 32'd9, ZERO, 1'b0, 1'b0, 32'd0, ZERO, 32'd0, 1'b0, 0, k);
    wait_until(k + PERIOD + 60);
    check("pre_reset_count", 640'(hash_count), 640'(1));
    rstb = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    rstb = 1'b1;
    check("midrst_ena_left", 640'(ena_q.size()), 640'(0));
    repeat (300) @(negedge clk);
    check("post_rst_busy", 640'(busy), 640'(0));
    check("post_rst_count", 640'(hash_count), 640'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/blake_nonce_scheduler.md
Name: blake_nonce_scheduler

Overview:
Sequences the single-block BLAKE-512 core over an inclusive range of 32-bit nonces on a fixed 640-bit header. Each hash is compared against a 512-bit target, and the search stops on the first hit. Sits between the host/register interface and one blake_hw instance, and owns that core's ena/din. Only one hash is ever in flight, because the core cannot accept a new ena while it is computing.

Parameters:
RDY_TIMEOUT, 200, max cycles spent in WAIT before declaring a core fault.

Ports:
clk  in  1  clock
rstb  in  1  reset, synchronous, active-low (also drives the core's rstb)
start  in  1  begin search; sampled only in IDLE
abort  in  1  stop request; sticky until honoured
header  in  640  header template; bits [31:0] are replaced by the nonce
nonce_start  in  32  first nonce (inclusive)
nonce_end  in  32  last nonce (inclusive)
target  in  512  hit when hash <= target, unsigned, bit 511 = MSB
core_ena  out  1  one-cycle start pulse to the core
core_din  out  640  {hdr_q[639:32], nonce_q}
core_rdy  in  1  core done pulse; core_dout is valid only in this cycle
core_dout  in  512  hash result
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle completion pulse
found  out  1  hit flag
found_nonce  out  32  nonce of the hit
found_hash  out  512  hash of the hit
hash_count  out  32  number of hashes completed in the current search
err_timeout  out  1  core failed to assert core_rdy within RDY_TIMEOUT

Behaviour:
- Reset: every output and register is 0; FSM goes to IDLE. Reset mid-search abandons the search with no done pulse.
- States: IDLE, ISSUE, WAIT, NEXT, FINISH.
- IDLE
  - On start, latch header, nonce_start, nonce_end and target.
  - Clear found, found_nonce, found_hash, hash_count, err_timeout and the abort flag.
  - If nonce_end < nonce_start, go to FINISH (empty range, core never started); otherwise go to ISSUE with nonce_q = nonce_start.
  - start while busy is ignored.
- ISSUE: core_ena = 1 for exactly one cycle; clear the timeout counter; go to WAIT.
- WAIT
  - On core_rdy, compare core_dout <= target_q and register the result plus core_dout; increment hash_count; go to NEXT.
  - The core delivers core_rdy 129 cycles after core_ena.
  - If the timeout counter reaches RDY_TIMEOUT without core_rdy, set err_timeout and go to FINISH.
- NEXT, in priority order:
  1. Hit: set found, capture found_nonce and found_hash, go to FINISH.
  2. nonce_q == nonce_end: go to FINISH.
  3. Abort flag set: go to FINISH.
  4. Otherwise nonce_q++ and go to ISSUE.
  - The equality test happens before the increment, so nonce_end = 0xFFFFFFFF never wraps.
- FINISH: done = 1 for one cycle; go to IDLE.
- Hash period is 131 cycles: ISSUE, then 129 cycles of WAIT, then NEXT.
- Timing for a search of N hashes: start sampled at edge k gives done at cycle k+1+131·N. An empty range gives done at k+1.
- core_ena is never asserted in the cycle core_rdy is high or during WAIT. Asserting it mid-computation would corrupt the core state.
- Abort
  - Captured in any non-IDLE state.
  - Takes effect only at NEXT; an in-flight hash always completes and is still checked for a hit, and a hit takes priority.
  - Abort in IDLE is ignored.
- Result outputs hold their values after done until the next accepted start.
- A simultaneous hit and nonce_q == nonce_end reports found = 1.
- The comparison is unsigned over the full 512 bits; hash == target counts as a hit.

Decomposition:
- Package blake_pkg holds:
  - HDR_W = 640, HASH_W = 512, NONCE_W = 32;
  - CORE_LAT = 129;
  - the scheduler state enum.
- No sub-module is needed inside the scheduler.
- The 512-bit comparator is a single expression.
- blake_hw is instantiated beside the scheduler in the wrapper, not inside it.

Test Plan:
1. target = all ones, nonce_start = nonce_end = 5 -> found = 1, found_nonce = 5, hash_count = 1, done at k+132, core_ena pulses once.
2. target = 0, range 0..3 -> found = 0, hash_count = 4, done at k+525, core_ena pulses 4 times 131 cycles apart, core_din[31:0] = 0, 1, 2, 3.
3. Range 0xFFFFFFFF..0xFFFFFFFF with target = 0 -> exactly one hash, hash_count = 1, no wrap to 0.
4. Range 10..2 -> done at k+1, hash_count = 0, core_ena never asserted.
5. Range 0..9, abort pulsed 50 cycles into the first WAIT -> hash_count = 1, found = 0, done at k+132. Repeat with target = all ones -> found = 1.
6. Core stub that never asserts core_rdy -> err_timeout = 1 and done RDY_TIMEOUT+2 cycles after core_ena. Then rstb low mid-WAIT -> all outputs 0, busy = 0, no done pulse.
